// File: rtl/array_loader_if.sv
// Stream-in and search-side signals of the array loader, bundled for port connection.
interface array_loader_if #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned DEPTH  = 8
);
    localparam int unsigned CWIDTH = $clog2(DEPTH + 1);

    // Sample stream
    logic                             s_valid;
    logic [DWIDTH-1:0]                s_data;
    logic                             s_last;
    logic                             s_ready;

    // Search-stage side
    logic [DEPTH-1:0][DWIDTH-1:0]     array;
    logic                             en;
    logic [CWIDTH-1:0]                count;
    logic                             search_dv;
    logic                             busy;

    // Driver of samples and consumer of the array (producer + search stage)
    modport master (
        output s_valid, s_data, s_last, search_dv,
        input  s_ready, array, en, count, busy
    );

    // The loader itself
    modport slave (
        input  s_valid, s_data, s_last, search_dv,
        output s_ready, array, en, count, busy
    );
endinterface

// File: rtl/array_loader.sv
// Frame loader for the min/max array search: collects samples into a register array,
// pads short frames with a value that can never win, launches the search and holds the
// array until the search reports a result.
module array_loader #(
    parameter int unsigned DWIDTH     = 8,
    parameter int unsigned DEPTH      = 8,
    parameter logic        SEARCH_MAX = 1'b0,
    localparam int unsigned AWIDTH    = $clog2(DEPTH),
    localparam int unsigned CWIDTH    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    array_loader_if.slave       bus
);

    // Pad loses the search: all ones for a min search, all zeros for a max search.
    localparam logic [DWIDTH-1:0] PAD_VAL  = {DWIDTH{~SEARCH_MAX}};
    localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        StFill,
        StPad,
        StLaunch,
        StWait
    } state_e;

    state_e                       state_q, state_d;
    logic [AWIDTH-1:0]            wptr_q, wptr_d;
    logic [DEPTH-1:0][DWIDTH-1:0] array_q, array_d;
    logic [CWIDTH-1:0]            count_q, count_d;
    logic                         en_q, en_d;
    logic                         accept;

    // Handshake decodes the state register only.
    assign bus.s_ready = (state_q == StFill);
    assign bus.busy    = (state_q != StFill);
    assign accept      = bus.s_valid && (state_q == StFill);

    assign bus.array   = array_q;
    assign bus.count   = count_q;
    assign bus.en      = en_q;

    // Next-state, write pointer, array contents and entry count.
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        array_d = array_q;
        count_d = count_q;

        unique case (state_q)
            StFill: begin
                if (accept) begin
                    array_d[wptr_q] = bus.s_data;
                    count_d         = CWIDTH'(wptr_q) + CWIDTH'(1);
                    if (wptr_q == LAST_IDX) begin
                        // A full frame needs no padding; s_last is irrelevant here.
                        state_d = StLaunch;
                        wptr_d  = '0;
                    end else if (bus.s_last) begin
                        // Keep wptr on the last real entry so PAD knows where to start.
                        state_d = StPad;
                    end else begin
                        wptr_d = wptr_q + AWIDTH'(1);
                    end
                end
            end

            StPad: begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (AWIDTH'(i) > wptr_q) begin
                        array_d[i] = PAD_VAL;
                    end
                end
                state_d = StLaunch;
                wptr_d  = '0;
            end

            StLaunch: begin
                // A combinational search may answer in the launch cycle itself.
                state_d = bus.search_dv ? StFill : StWait;
            end

            StWait: begin
                if (bus.search_dv) begin
                    state_d = StFill;
                end
            end

            default: begin
                state_d = StFill;
                wptr_d  = '0;
            end
        endcase
    end

    // en is registered and high exactly while the state register holds LAUNCH.
    always_comb begin
        en_d = (state_d == StLaunch);
    end

    // State, pointer, array and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFill;
            wptr_q  <= '0;
            array_q <= '0;
            count_q <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            array_q <= array_d;
            count_q <= count_d;
            en_q    <= en_d;
        end
    end

endmodule

// File: tb/tb_array_loader.sv
// Directed bench for array_loader: one instance per pad polarity, driven in lockstep.
module tb_array_loader;

    localparam int unsigned DW = 8;
    localparam int unsigned DP = 8;

    logic clk = 1'b0;
    logic rst;

    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          search_dv;

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned en_seen = 0;

    logic [DP-1:0][DW-1:0] exp0, exp1, held0;

    array_loader_if #(.DWIDTH(DW), .DEPTH(DP)) if0 ();
    array_loader_if #(.DWIDTH(DW), .DEPTH(DP)) if1 ();

    assign if0.s_valid   = s_valid;
    assign if0.s_data    = s_data;
    assign if0.s_last    = s_last;
    assign if0.search_dv = search_dv;
    assign if1.s_valid   = s_valid;
    assign if1.s_data    = s_data;
    assign if1.s_last    = s_last;
    assign if1.search_dv = search_dv;

    array_loader #(.DWIDTH(DW), .DEPTH(DP), .SEARCH_MAX(1'b0)) u_min (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    array_loader #(.DWIDTH(DW), .DEPTH(DP), .SEARCH_MAX(1'b1)) u_max (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (if0.en) en_seen++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic rdy, input logic en, input logic bsy);
        chk({tag, "_ready"}, 64'(if0.s_ready), 64'(rdy));
        chk({tag, "_en"},    64'(if0.en),      64'(en));
        chk({tag, "_busy"},  64'(if0.busy),    64'(bsy));
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        s_valid   = 1'b0;
        s_data    = '0;
        s_last    = 1'b0;
        search_dv = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk_ctl("rst", 1'b1, 1'b0, 1'b0);
        chk("rst_array", 64'(if0.array), 64'h0);
        chk("rst_count", 64'(if0.count), 64'd0);

        // 1: full frame 5,3,9,1,7,2,8,4
        send(8'd5, 1'b0); send(8'd3, 1'b0); send(8'd9, 1'b0); send(8'd1, 1'b0);
        send(8'd7, 1'b0); send(8'd2, 1'b0); send(8'd8, 1'b0);
        chk_ctl("t1_fill", 1'b1, 1'b0, 1'b0);
        send(8'd4, 1'b1);
        exp0 = {8'd4, 8'd8, 8'd2, 8'd7, 8'd1, 8'd9, 8'd3, 8'd5};
        chk_ctl("t1_launch", 1'b0, 1'b1, 1'b1);
        chk("t1_array", 64'(if0.array), 64'(exp0));
        chk("t1_count", 64'(if0.count), 64'd8);
        tick();
        chk_ctl("t1_wait", 1'b0, 1'b0, 1'b1);
        search_dv = 1'b1;
        tick();
        search_dv = 1'b0;
        chk_ctl("t1_release", 1'b1, 1'b0, 1'b0);
        chk("t1_array_kept", 64'(if0.array), 64'(exp0));

        // 2: short frame 10,20,30 -> PAD cycle, en two cycles after last accept
        send(8'd10, 1'b0); send(8'd20, 1'b0); send(8'd30, 1'b1);
        chk_ctl("t2_pad", 1'b0, 1'b0, 1'b1);
        chk("t2_count", 64'(if0.count), 64'd3);
        tick();
        exp0 = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'd30, 8'd20, 8'd10};
        exp1 = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'd30, 8'd20, 8'd10};
        chk_ctl("t2_launch", 1'b0, 1'b1, 1'b1);
        chk("t2_array_min", 64'(if0.array), 64'(exp0));
        chk("t2_array_max", 64'(if1.array), 64'(exp1));

        // 5: search_dv in the launch cycle skips WAIT
        search_dv = 1'b1;
        tick();
        search_dv = 1'b0;
        chk_ctl("t5_fill", 1'b1, 1'b0, 1'b0);
        chk("t5_max_ready", 64'(if1.s_ready), 64'd1);

        // 3: single-sample frame
        en_seen = 0;
        send(8'h40, 1'b1);
        chk("t3_count", 64'(if1.count), 64'd1);
        chk_ctl("t3_pad", 1'b0, 1'b0, 1'b1);
        tick();
        exp0 = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h40};
        exp1 = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40};
        chk("t3_en", 64'(if1.en), 64'd1);
        chk("t3_array_max", 64'(if1.array), 64'(exp1));
        chk("t3_array_min", 64'(if0.array), 64'(exp0));

        // 4: hold for 5 cycles with s_valid high
        held0     = exp0;
        s_valid   = 1'b1;
        s_data    = 8'h99;
        s_last    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_ctl("t4_hold", 1'b0, 1'b0, 1'b1);
        end
        chk("t4_array_held", 64'(if0.array), 64'(held0));
        chk("t4_count_held", 64'(if0.count), 64'd1);
        chk("t3_en_once", 64'(en_seen), 64'd1);
        search_dv = 1'b1;
        tick();
        search_dv = 1'b0;
        chk_ctl("t4_release", 1'b1, 1'b0, 1'b0);
        chk("t4_no_accept_dv", 64'(if0.array), 64'(held0));
        tick();
        held0[0] = 8'h99;
        chk("t4_first_accept", 64'(if0.array), 64'(held0));
        chk("t4_first_count", 64'(if0.count), 64'd1);
        s_valid = 1'b0;

        // 6: reset after 4 samples, then a fresh full frame
        send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hA3, 1'b0);
        chk("t6_partial_count", 64'(if0.count), 64'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_ctl("t6_rst", 1'b1, 1'b0, 1'b0);
        chk("t6_rst_array", 64'(if0.array), 64'h0);
        chk("t6_rst_count", 64'(if0.count), 64'd0);
        en_seen = 0;
        for (int i = 0; i < 8; i++) begin
            send(8'(8'h11 + i), (i == 7));
        end
        exp0 = {8'h18, 8'h17, 8'h16, 8'h15, 8'h14, 8'h13, 8'h12, 8'h11};
        chk_ctl("t6_launch", 1'b0, 1'b1, 1'b1);
        chk("t6_array", 64'(if0.array), 64'(exp0));
        chk("t6_array_max", 64'(if1.array), 64'(exp0));
        chk("t6_count", 64'(if0.count), 64'd8);
        search_dv = 1'b1;
        tick();
        search_dv = 1'b0;
        tick();
        chk("t6_en_once", 64'(en_seen), 64'd1);
        chk_ctl("t6_idle", 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
